// File: rtl/fetch_sequencer.sv
// Program-counter / fetch controller in front of a 1-cycle registered instruction memory.
// Optional FETCH_PERF_EN adds saturating fetch/bubble counters.
module fetch_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LAST_ADDR  = 80,
  parameter int unsigned PROG0_BASE = 0,
  parameter int unsigned PROG1_BASE = 15,
  parameter int unsigned PROG2_BASE = 21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [25:0]       jump_target,
  input  logic              branch_en,
  input  logic [15:0]       branch_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] address,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       bubble_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic              fault_q;

  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_en;
  logic              redir_bad;
  logic              issue;
  logic              start_acc;

  always_comb begin
    base_addr = ADDR_W'(PROG0_BASE);
    unique case (prog_sel)
      2'd1:    base_addr = ADDR_W'(PROG1_BASE);
      2'd2:    base_addr = ADDR_W'(PROG2_BASE);
      default: base_addr = ADDR_W'(PROG0_BASE);
    endcase

    seq_addr  = (addr_q == ADDR_W'(LAST_ADDR)) ? '0 : addr_q + ADDR_W'(1);
    redir_en  = jump_en | branch_en;
    redir_tgt = jump_en ? jump_target[ADDR_W-1:0] : branch_target[ADDR_W-1:0];
    redir_bad = (redir_tgt > ADDR_W'(LAST_ADDR));
    // only an undisturbed FETCH cycle hands the current address to the memory
    issue     = (state_q == S_FETCH) & ~halt & ~redir_en & ~stall;
    start_acc = start & (state_q != S_FETCH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= issue;
      if (issue) pc_q <= addr_q;

      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q <= S_FETCH;
            addr_q  <= base_addr;
            fault_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (halt) begin
            state_q <= S_HALT;
          end else if (redir_en) begin
            if (redir_bad) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              addr_q <= redir_tgt;
            end
          end else if (!stall) begin
            addr_q <= seq_addr;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address     = addr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = pc_q;
  assign busy        = (state_q == S_FETCH);
  assign fault       = fault_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge clock) begin
    if (reset || start_acc) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (state_q == S_FETCH) begin
      if (issue) begin
        if (fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end else begin
        if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-cycle comparison against a behavioural model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_fetch_sequencer;

  localparam int LAST = 80;

  logic        clock = 1'b0;
  logic        reset, start, stall, jump_en, branch_en, halt;
  logic [1:0]  prog_sel;
  logic [25:0] jump_target;
  logic [15:0] branch_target;
  logic [9:0]  address, instr_pc;
  logic        instr_valid, busy, fault;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count, bubble_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(
    .ADDR_W(10), .LAST_ADDR(80), .PROG0_BASE(0), .PROG1_BASE(15), .PROG2_BASE(21)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .prog_sel(prog_sel),
    .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
    .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
    .address(address), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .busy(busy), .fault(fault)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running flag, current address, last issued word.
  bit m_run, m_valid, m_fault, m_iss;
  int m_addr, m_pc, m_tgt, m_fc, m_bc;

  function automatic int base_of(input int s);
    if (s == 1) return 15;
    if (s == 2) return 21;
    return 0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_run = 0; m_valid = 0; m_fault = 0; m_addr = 0; m_pc = 0; m_fc = 0; m_bc = 0;
    end else begin
      m_iss = m_run && !halt && !jump_en && !branch_en && !stall;
      if (m_run) begin
        if (m_iss) m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
        else       m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
      end
      m_valid = m_iss;
      if (m_iss) m_pc = m_addr;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_addr = base_of(int'(prog_sel)); m_fault = 0; m_fc = 0; m_bc = 0;
        end
      end else if (halt) begin
        m_run = 0;
      end else if (jump_en || branch_en) begin
        m_tgt = jump_en ? int'(jump_target) % 1024 : int'(branch_target) % 1024;
        if (m_tgt > LAST) begin m_fault = 1; m_run = 0; end
        else m_addr = m_tgt;
      end else if (!stall) begin
        m_addr = (m_addr + 1) % (LAST + 1);
      end
    end
  end

  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      chk("model_address", 32'(address), 32'(m_addr));
      chk("model_valid",   32'(instr_valid), 32'(m_valid));
      chk("model_pc",      32'(instr_pc), 32'(m_pc));
      chk("model_busy",    32'(busy), 32'(m_run));
      chk("model_fault",   32'(fault), 32'(m_fault));
`ifdef FETCH_PERF_EN
      chk("model_fetch_count",  32'(fetch_count), 32'(m_fc));
      chk("model_bubble_count", 32'(bubble_count), 32'(m_bc));
`endif
    end
  end

  task automatic idle_in();
    start = 0; stall = 0; jump_en = 0; branch_en = 0; halt = 0;
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  int low;

  initial begin
    reset = 1; idle_in(); prog_sel = 0; jump_target = '0; branch_target = '0;
    cyc(); cyc();
    chk("rst_address", 32'(address), 0);
    chk("rst_valid",   32'(instr_valid), 0);
    chk("rst_pc",      32'(instr_pc), 0);
    chk("rst_fault",   32'(fault), 0);
    chk("rst_busy",    32'(busy), 0);

    // program 1 entry and first valid word
    reset = 0; start = 1; prog_sel = 1; cyc(); start = 0;
    chk("p1_addr0", 32'(address), 15);
    chk("p1_valid0", 32'(instr_valid), 0);
    cyc();
    chk("p1_addr1", 32'(address), 16);
    chk("p1_valid1", 32'(instr_valid), 1);
    chk("p1_pc1", 32'(instr_pc), 15);
    cyc();
    chk("p1_addr2", 32'(address), 17);
    chk("p1_pc2", 32'(instr_pc), 16);

    // jump from 9 to 6 squashes the word at 9
    reset = 1; cyc(); reset = 0; start = 1; prog_sel = 0; cyc(); start = 0;
    repeat (9) cyc();
    chk("pre_jump_addr", 32'(address), 9);
    jump_en = 1; jump_target = 26'd6; cyc(); jump_en = 0;
    chk("jump_addr", 32'(address), 6);
    chk("jump_squash", 32'(instr_valid), 0);
    cyc();
    chk("jump_valid", 32'(instr_valid), 1);
    chk("jump_pc", 32'(instr_pc), 6);

    // stall held 3 cycles at 20
    repeat (13) cyc();
    chk("pre_stall_addr", 32'(address), 20);
    stall = 1;
    repeat (3) begin
      cyc();
      chk("stall_addr", 32'(address), 20);
      chk("stall_valid", 32'(instr_valid), 0);
    end
    stall = 0; cyc();
    chk("unstall_valid", 32'(instr_valid), 1);
    chk("unstall_pc", 32'(instr_pc), 20);
    chk("unstall_addr", 32'(address), 21);

    // jump beats branch
    jump_en = 1; branch_en = 1; jump_target = 26'd5; branch_target = 16'd21; cyc(); idle_in();
    chk("jump_wins", 32'(address), 5);

    // out-of-range branch faults and halts
    branch_en = 1; branch_target = 16'd100; cyc(); idle_in();
    chk("fault_set", 32'(fault), 1);
    chk("fault_busy", 32'(busy), 0);
    chk("fault_addr_held", 32'(address), 5);
    start = 1; prog_sel = 0; cyc(); start = 0;
    chk("fault_clear", 32'(fault), 0);
    chk("restart_addr", 32'(address), 0);
    chk("restart_busy", 32'(busy), 1);

    // wrap past LAST_ADDR, then reset mid-run
    branch_en = 1; branch_target = 16'd78; cyc(); idle_in();
    chk("wrap_78", 32'(address), 78);
    cyc(); cyc();
    chk("wrap_80", 32'(address), 80);
    cyc();
    chk("wrap_0", 32'(address), 0);
    chk("wrap_pc80", 32'(instr_pc), 80);
    reset = 1; cyc(); reset = 0;
    chk("midrst_addr", 32'(address), 0);
    chk("midrst_valid", 32'(instr_valid), 0);
    chk("midrst_busy", 32'(busy), 0);

    // randomized traffic
    repeat (4000) begin
      reset     = ($urandom % 64) == 0;
      start     = ($urandom % 6) == 0;
      prog_sel  = 2'($urandom % 4);
      stall     = ($urandom % 4) == 0;
      jump_en   = ($urandom % 12) == 0;
      branch_en = ($urandom % 12) == 0;
      halt      = ($urandom % 40) == 0;
      low = (($urandom % 10) == 0) ? 81 + int'($urandom % 943) : int'($urandom % 81);
      jump_target   = 26'(($urandom << 10) | 32'(low));
      low = (($urandom % 10) == 0) ? 81 + int'($urandom % 943) : int'($urandom % 81);
      branch_target = 16'(($urandom << 10) | 32'(low));
      cyc();
    end
    reset = 0; idle_in(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
